// File: rtl/sd_tag_scanner_if.sv
// Signal bundle between the tag scanner, the SD block-read port, the SRAM buffer
// and the application FSM. The scanner uses the master side.
interface sd_tag_scanner_if;
  logic        start;
  logic        init_finish;
  logic        rd_req;
  logic [31:0] rd_adr;
  logic        out_valid;
  logic [7:0]  sdcd_out;
  logic        buf_we;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_din;
  logic        busy;
  logic        found;
  logic        fail;
  logic        timeout_err;
  logic [31:0] found_adr;
  logic [15:0] blk_cnt;

  modport master (
    input  start, init_finish, out_valid, sdcd_out,
    output rd_req, rd_adr, buf_we, buf_addr, buf_din,
           busy, found, fail, timeout_err, found_adr, blk_cnt
  );

  modport slave (
    output start, init_finish, out_valid, sdcd_out,
    input  rd_req, rd_adr, buf_we, buf_addr, buf_din,
           busy, found, fail, timeout_err, found_adr, blk_cnt
  );
endinterface

// File: rtl/sd_tag_scanner.sv
// Walks SD blocks from START_ADDR, streams each into the SRAM buffer and stops at
// the first block whose leading 8 bytes equal TAG.
module sd_tag_scanner #(
  parameter logic [31:0] START_ADDR = 32'd8192,
  parameter logic [15:0] MAX_BLOCKS = 16'd1024,
  parameter logic [63:0] TAG        = 64'h444C41425F544147,
  parameter logic [23:0] TIMEOUT    = 24'd5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  sd_tag_scanner_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_READ, S_CHECK, S_DONE, S_FAIL
  } state_t;

  state_t      state;
  logic [9:0]  byte_cnt;
  logic        match;
  logic [23:0] wdog;
  logic        rd_req;
  logic [31:0] rd_adr;
  logic        busy;
  logic        found;
  logic        fail;
  logic        timeout_err;
  logic [31:0] found_adr;
  logic [15:0] blk_cnt;

  logic [5:0]  tag_sel;
  logic [7:0]  tag_byte;
  logic        byte_in;

  // Byte 0 of the tag sits in the top byte, so the select counts down.
  assign tag_sel  = {~byte_cnt[2:0], 3'b000};
  assign tag_byte = TAG[tag_sel +: 8];
  assign byte_in  = (state == S_READ) && bus.out_valid && !byte_cnt[9];

  assign bus.buf_we      = byte_in;
  assign bus.buf_addr    = byte_cnt[8:0];
  assign bus.buf_din     = bus.sdcd_out;
  assign bus.rd_req      = rd_req;
  assign bus.rd_adr      = rd_adr;
  assign bus.busy        = busy;
  assign bus.found       = found;
  assign bus.fail        = fail;
  assign bus.timeout_err = timeout_err;
  assign bus.found_adr   = found_adr;
  assign bus.blk_cnt     = blk_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      byte_cnt    <= '0;
      match       <= 1'b0;
      wdog        <= '0;
      rd_req      <= 1'b0;
      rd_adr      <= START_ADDR;
      busy        <= 1'b0;
      found       <= 1'b0;
      fail        <= 1'b0;
      timeout_err <= 1'b0;
      found_adr   <= '0;
      blk_cnt     <= '0;
    end else begin
      rd_req <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (bus.start && bus.init_finish) begin
            state       <= S_ISSUE;
            rd_req      <= 1'b1;
            rd_adr      <= START_ADDR;
            blk_cnt     <= '0;
            busy        <= 1'b1;
            found       <= 1'b0;
            fail        <= 1'b0;
            timeout_err <= 1'b0;
          end
        end
        S_ISSUE: begin
          byte_cnt <= '0;
          match    <= 1'b1;
          wdog     <= '0;
          state    <= S_READ;
        end
        S_READ: begin
          if (byte_in) begin
            byte_cnt <= byte_cnt + 10'd1;
            wdog     <= '0;
            if (byte_cnt < 10'd8 && bus.sdcd_out != tag_byte) match <= 1'b0;
            // Leave on the 512th strobe so S_CHECK follows it directly.
            if (byte_cnt == 10'd511) state <= S_CHECK;
          end else if (wdog == TIMEOUT - 24'd1) begin
            state       <= S_FAIL;
            busy        <= 1'b0;
            fail        <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            wdog <= wdog + 24'd1;
          end
        end
        S_CHECK: begin
          blk_cnt <= blk_cnt + 16'd1;
          if (match) begin
            state     <= S_DONE;
            found_adr <= rd_adr;
            found     <= 1'b1;
            busy      <= 1'b0;
          end else if (blk_cnt + 16'd1 == MAX_BLOCKS) begin
            state <= S_FAIL;
            fail  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            rd_adr <= rd_adr + 32'd1;
            rd_req <= 1'b1;
            state  <= S_ISSUE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
